spdif_encoder: RTL and testbench
================================

// Module: spdif_encoder
// PURPOSE
//  Transmit side of the S/PDIF link: takes stereo 24-bit PCM frames via valid/ready and emits an IEC 60958 biphase-mark stream.
//  Emits B/M/W preambles, V/U/C/P bits and a 192-frame channel-status block.
//  Sits between the audio datapath and the optical/coax driver, and is the loopback source for spdif_decoder tests.
// PARAMETERS
//  CLK_DIV   4             clk_in cycles per UI (half-bit); 128 UI/frame (24.576 MHz -> 48 kHz)
//  CS_WORD   32'h02000004  channel-status bits 0..31 (consumer, copy ok, fs=48k); bits 32..191 = 0
// PORTS
//  clk_in        in   1   system clock
//  resetb        in   1   async active-low reset
//  enable        in   1   transmit enable
//  sample_l      in   24  left PCM, two's complement
//  sample_r      in   24  right PCM
//  sample_valid  in   1   sample pair present
//  sample_ready  out  1   holding register empty; transfer on valid&ready
//  spdif_out     out  1   BMC line output
//  frame_start   out  1   1-cycle pulse on first UI of every left subframe
//  block_start   out  1   1-cycle pulse on first UI of frame 0 (B preamble)
//  underrun      out  1   1-cycle pulse when frame starts with holding reg empty
// BEHAVIOUR
//  Reset: spdif_out=0, sample_ready=1, frame_start=block_start=underrun=0.
//   Holding reg empty, frame_cnt=0, slot=0, UI divider=0.
//  enable=0: same state as reset, except holding-register contents/flag are kept.
//   Accepts 1 pair while disabled.
//  enable 0->1: divider starts; first UI (frame 0, B preamble) appears CLK_DIV cycles later.
//  UI tick: divider counts 0..CLK_DIV-1; tick at CLK_DIV-1; spdif_out updates only on ticks (registered).
//  Buffering: 2 stages (holding reg + active reg).
//   At each frame start, holding -> active, holding empties, sample_ready=1 the next cycle.
//   valid&ready in the same cycle as the frame-start transfer: the new pair enters holding; ready stays 0.
//  Underrun: if holding is empty at frame start, active<=0, V=1 in both subframes, underrun pulses. Otherwise V=0.
//  Subframe slots 0..31, 2 UI each:
//   0-3 preamble; 4-27 audio LSB first; 28 V; 29 U=0; 30 C; 31 P.
//   P is even parity over slots 4..30.
//  Subframe order: L then R. L preamble = B when frame_cnt==0, else M. R preamble = W.
//  Preamble UI patterns (line level 0 before):
//   B 11101000, M 11100010, W 11100100.
//   Invert the whole pattern if the line level before is 1.
//  Data slots: toggle at slot start; toggle again mid-slot iff bit=1.
//  C bit = CS_WORD[frame_cnt] for frame_cnt<32, else 0. Same C in L and R.
//  frame_cnt: 0..191, increments after the R subframe; 191 wraps to 0 and block_start fires at the next B.
//  FSM:
//   IDLE (enable=0) -> PRE (slots 0-3) -> DATA (4-30) -> PAR (31);
//   PAR -> PRE of the next subframe; enable=0 in any state -> IDLE at once.
//  Mid-operation reset or disable aborts the subframe; there is no partial-frame flush.
// TESTING
//  1. Reset, enable=1, L=24'h000001 R=0 preloaded:
//     frame 0 L UIs = 11101000, slot4 = "10", slots 5-30 alternate, P=1.
//     block_start and frame_start pulse on the first UI.
//  2. Continuous ramp L=R=n, 400 frames:
//     loop through spdif_decoder; decoded words match; no underrun.
//     block_start every 192*512 clk_in cycles.
//  3. No sample_valid: underrun pulses every frame; V=1; audio slots all 0; line still toggles each slot.
//  4. CS_WORD default: C bits decoded over a block = 0 except frames 2 and 25 = 1.
//  5. valid held high from reset:
//     2 pairs accepted before frame 0 ends; ready=0 until the next frame start, then 1 cycle later.
//  6. enable dropped mid-DATA: spdif_out=0 next cycle.
//     Re-enable restarts at B, frame_cnt=0; the held pair is sent in frame 0.

Source files
------------

// File: rtl/spdif_encoder.sv
// IEC 60958 (S/PDIF) transmitter: stereo 24-bit PCM in, biphase-mark line out.
// Two-stage sample buffering (holding + active), B/M/W preambles, V/U/C/P bits.
module spdif_encoder #(
   parameter int unsigned CLK_DIV = 4,
   parameter logic [31:0] CS_WORD = 32'h02000004
) (
   input  logic        clk_in,
   input  logic        resetb,
   input  logic        enable,
   input  logic [23:0] sample_l,
   input  logic [23:0] sample_r,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        spdif_out,
   output logic        frame_start,
   output logic        block_start,
   output logic        underrun
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [7:0] PreB = 8'b11101000;
   localparam logic [7:0] PreM = 8'b11100010;
   localparam logic [7:0] PreW = 8'b11100100;

   typedef enum logic [1:0] {StIdle, StPre, StData, StPar} state_e;

   state_e          state_q;
   logic [DivW-1:0] div_q;
   logic            sub_q;       // 0 = left subframe, 1 = right
   logic [4:0]      slot_q;
   logic            half_q;
   logic [7:0]      frame_q;
   logic [23:0]     hold_l_q, hold_r_q, act_l_q, act_r_q;
   logic            hold_full_q;
   logic            v_q;
   logic            pre_lvl_q;   // line level just before the current preamble

   logic            tick, accept, frame_tick;
   logic [23:0]     cur_sample;
   logic            c_bit, data_bit, par_bit, pre_lvl, next_ui;
   logic [7:0]      pre_pat;
   logic [2:0]      pre_idx;
   logic [4:0]      next_slot;
   logic [4:0]      aud_idx;

   assign sample_ready = ~hold_full_q;
   assign tick         = enable && (div_q == DivW'(CLK_DIV - 1));
   assign accept       = sample_valid && ~hold_full_q;
   assign frame_tick   = tick && ~sub_q && (slot_q == 5'd0) && ~half_q;

   always_comb begin
      cur_sample = sub_q ? act_r_q : act_l_q;
      c_bit      = (frame_q[7:5] == 3'd0) && CS_WORD[frame_q[4:0]];
      par_bit    = (^cur_sample) ^ v_q ^ c_bit;
      aud_idx    = slot_q - 5'd4;
      unique case (slot_q)
         5'd28:   data_bit = v_q;
         5'd29:   data_bit = 1'b0;
         5'd30:   data_bit = c_bit;
         default: data_bit = cur_sample[aud_idx];
      endcase
      if (sub_q) begin
         pre_pat = PreW;
      end else if (frame_q == 8'd0) begin
         pre_pat = PreB;
      end else begin
         pre_pat = PreM;
      end
      pre_idx = 3'd7 - {slot_q[1:0], half_q};
      pre_lvl = ((slot_q == 5'd0) && ~half_q) ? spdif_out : pre_lvl_q;
      unique case (state_q)
         StIdle, StPre: next_ui = pre_pat[pre_idx] ^ pre_lvl;
         StData:        next_ui = half_q ? (spdif_out ^ data_bit) : ~spdif_out;
         StPar:         next_ui = half_q ? (spdif_out ^ par_bit) : ~spdif_out;
         default:       next_ui = 1'b0;
      endcase
      next_slot = half_q ? slot_q + 5'd1 : slot_q;
   end

   always_ff @(posedge clk_in or negedge resetb) begin
      if (!resetb) begin
         state_q     <= StIdle;
         div_q       <= '0;
         sub_q       <= 1'b0;
         slot_q      <= 5'd0;
         half_q      <= 1'b0;
         frame_q     <= 8'd0;
         hold_l_q    <= 24'd0;
         hold_r_q    <= 24'd0;
         act_l_q     <= 24'd0;
         act_r_q     <= 24'd0;
         hold_full_q <= 1'b0;
         v_q         <= 1'b0;
         pre_lvl_q   <= 1'b0;
         spdif_out   <= 1'b0;
         frame_start <= 1'b0;
         block_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         block_start <= 1'b0;
         underrun    <= 1'b0;
         if (accept) begin
            hold_l_q <= sample_l;
            hold_r_q <= sample_r;
         end
         // Frame-start transfer empties the holding reg unless a new pair lands now.
         if (frame_tick) begin
            hold_full_q <= accept;
         end else if (accept) begin
            hold_full_q <= 1'b1;
         end
         if (!enable) begin
            state_q   <= StIdle;
            div_q     <= '0;
            sub_q     <= 1'b0;
            slot_q    <= 5'd0;
            half_q    <= 1'b0;
            frame_q   <= 8'd0;
            pre_lvl_q <= 1'b0;
            spdif_out <= 1'b0;
         end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (state_q == StIdle) begin
               state_q <= StPre;
            end
            if (tick) begin
               spdif_out <= next_ui;
               if ((slot_q == 5'd0) && ~half_q) begin
                  pre_lvl_q <= spdif_out;
               end
               if (frame_tick) begin
                  frame_start <= 1'b1;
                  block_start <= (frame_q == 8'd0);
                  underrun    <= ~hold_full_q;
                  act_l_q     <= hold_full_q ? hold_l_q : 24'd0;
                  act_r_q     <= hold_full_q ? hold_r_q : 24'd0;
                  v_q         <= ~hold_full_q;
               end
               half_q <= ~half_q;
               if (half_q) begin
                  slot_q <= next_slot;
                  if (slot_q == 5'd31) begin
                     sub_q <= ~sub_q;
                     if (sub_q) begin
                        frame_q <= (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
                     end
                  end
               end
               if (next_slot < 5'd4) begin
                  state_q <= StPre;
               end else if (next_slot == 5'd31) begin
                  state_q <= StPar;
               end else begin
                  state_q <= StData;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spdif_encoder.sv
// Self-checking bench for spdif_encoder: a frame-level line model built from the
// IEC 60958 rules is compared against the DUT on every cycle.
module tb_spdif_encoder;

   localparam int unsigned DIV = 2;
   localparam int FRAME_CYC = 128 * DIV;

   logic        clk_in = 1'b0;
   logic        resetb = 1'b0;
   logic        enable = 1'b0;
   logic [23:0] sample_l = 24'd0;
   logic [23:0] sample_r = 24'd0;
   logic        sample_valid = 1'b0;
   logic        sample_ready, spdif_out, frame_start, block_start, underrun;

   int vectors = 0;
   int miscompares = 0;

   spdif_encoder #(
      .CLK_DIV(DIV),
      .CS_WORD(32'h02000004)
   ) dut (
      .clk_in      (clk_in),
      .resetb      (resetb),
      .enable      (enable),
      .sample_l    (sample_l),
      .sample_r    (sample_r),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .spdif_out   (spdif_out),
      .frame_start (frame_start),
      .block_start (block_start),
      .underrun    (underrun)
   );

   always #5 clk_in = ~clk_in;

   // ---------------- behavioural model ----------------
   logic [31:0] cs_word = 32'h02000004;
   logic        m_ui [0:127];
   logic        m_full = 1'b0;
   logic [23:0] m_hl = 24'd0, m_hr = 24'd0;
   int          m_cnt = 0, m_uipos = 0, m_fno = 0;
   logic        m_out = 1'b0, m_fs = 1'b0, m_bs = 1'b0, m_ur = 1'b0;

   // Expected 128 UI levels of one frame, given the line level before it.
   function automatic void build_frame(input logic [23:0] l, input logic [23:0] r,
                                       input logic v, input int fno, input logic lvl_in);
      logic        lvl;
      logic [7:0]  pre;
      logic [31:0] bits;
      logic        c;
      logic        u0, u1;
      lvl = lvl_in;
      c = (fno < 32) ? cs_word[fno] : 1'b0;
      for (int s = 0; s < 2; s++) begin
         if (s == 1) pre = 8'b11100100;
         else if (fno == 0) pre = 8'b11101000;
         else pre = 8'b11100010;
         for (int k = 0; k < 8; k++) m_ui[s * 64 + k] = pre[7 - k] ^ lvl;
         lvl = m_ui[s * 64 + 7];
         bits = 32'd0;
         bits[27:4] = (s == 1) ? r : l;
         bits[28] = v;
         bits[30] = c;
         bits[31] = ^bits[30:4];
         for (int sl = 4; sl < 32; sl++) begin
            u0 = ~lvl;
            u1 = bits[sl] ? ~u0 : u0;
            m_ui[s * 64 + sl * 2] = u0;
            m_ui[s * 64 + sl * 2 + 1] = u1;
            lvl = u1;
         end
      end
   endfunction

   always @(posedge clk_in or negedge resetb) begin
      logic acc;
      if (!resetb) begin
         m_full = 1'b0; m_cnt = 0; m_uipos = 0; m_fno = 0;
         m_out = 1'b0; m_fs = 1'b0; m_bs = 1'b0; m_ur = 1'b0;
      end else begin
         acc = sample_valid && !m_full;
         m_fs = 1'b0; m_bs = 1'b0; m_ur = 1'b0;
         if (!enable) begin
            m_cnt = 0; m_uipos = 0; m_fno = 0; m_out = 1'b0;
         end else if (m_cnt == int'(DIV) - 1) begin
            m_cnt = 0;
            if (m_uipos == 0) begin
               m_fs = 1'b1;
               m_bs = (m_fno == 0);
               m_ur = !m_full;
               build_frame(m_full ? m_hl : 24'd0, m_full ? m_hr : 24'd0, !m_full, m_fno, m_out);
               m_full = 1'b0;
            end
            m_out = m_ui[m_uipos];
            m_uipos = (m_uipos + 1) % 128;
            if (m_uipos == 0) m_fno = (m_fno + 1) % 192;
         end else begin
            m_cnt++;
         end
         if (acc) begin
            m_hl = sample_l; m_hr = sample_r; m_full = 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   task automatic cmp1(input string name, input logic act, input logic exp);
      if (act !== exp) begin
         miscompares++;
         if (miscompares <= 30)
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   always @(negedge clk_in) begin
      vectors++;
      cmp1("spdif_out", spdif_out, m_out);
      cmp1("sample_ready", sample_ready, !m_full);
      cmp1("frame_start", frame_start, m_fs);
      cmp1("block_start", block_start, m_bs);
      cmp1("underrun", underrun, m_ur);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n, input int vprob, input bit rnd);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_in);
         #1;
         if (rnd) begin
            sample_valid = ($urandom_range(99) < 32'(vprob));
            sample_l = 24'($urandom);
            sample_r = 24'($urandom);
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [9:0] cap;
      logic [7:0] mp;
      bit         found;

      // Pin the model against hand-derived frames.
      build_frame(24'h000001, 24'd0, 1'b0, 0, 1'b0);
      for (int k = 0; k < 8; k++) mp[7 - k] = m_ui[k];
      chk("model_B_preamble", 32'(mp), 32'h000000E8);
      chk("model_slot4", {30'd0, m_ui[8], m_ui[9]}, 32'd2);
      chk("model_parity_one", 32'(m_ui[62] ^ m_ui[63]), 32'd1);
      build_frame(24'd0, 24'd0, 1'b1, 5, 1'b1);
      for (int k = 0; k < 8; k++) mp[7 - k] = m_ui[k];
      chk("model_M_inverted", 32'(mp), 32'h0000001D);
      chk("model_V_set", 32'(m_ui[56] ^ m_ui[57]), 32'd1);
      chk("model_zero_toggles", 32'(m_ui[10] ^ m_ui[9]), 32'd1);

      cycles(3, 0, 0);
      resetb = 1'b1;
      @(negedge clk_in);
      chk("reset_ready", 32'(sample_ready), 32'd1);
      chk("reset_out", 32'(spdif_out), 32'd0);
      #1;

      // Preload L=1, R=0 while disabled, then enable.
      sample_valid = 1'b1; sample_l = 24'h000001; sample_r = 24'd0;
      cycles(1, 0, 0);
      sample_valid = 1'b0;
      enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk_in);
         if (block_start) found = 1'b1;
      end
      chk("first_block_start_seen", 32'(found), 32'd1);
      chk("first_frame_start", 32'(frame_start), 32'd1);
      cap[9] = spdif_out;
      for (int k = 1; k < 10; k++) begin
         repeat (DIV) @(negedge clk_in);
         cap[9 - k] = spdif_out;
      end
      chk("frame0_first_10_ui", 32'(cap), 32'h3A2);
      #1;

      // No samples for two frames: underrun path.
      cycles(2 * FRAME_CYC, 0, 0);

      // Random traffic across more than one channel-status block.
      cycles(194 * FRAME_CYC, 90, 1);

      // Disable mid-frame, load a pair while idle, re-enable.
      cycles(40, 0, 0);
      enable = 1'b0;
      sample_valid = 1'b0;
      @(negedge clk_in);
      chk("disable_out_low", 32'(spdif_out), 32'd0);
      #1;
      sample_valid = 1'b1; sample_l = 24'hABCDEF; sample_r = 24'h123456;
      cycles(3, 0, 0);
      sample_valid = 1'b0;
      cycles(4, 0, 0);
      enable = 1'b1;
      cycles(2 * FRAME_CYC, 0, 0);
      cycles(2 * FRAME_CYC, 50, 1);

      // Asynchronous reset in the middle of a frame.
      resetb = 1'b0;
      cycles(3, 70, 1);
      resetb = 1'b1;
      cycles(3 * FRAME_CYC, 70, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
